// File: rtl/axi_lite_mem_loader.sv
// AXI4-Lite read master that copies LENGTH consecutive words from
// off-chip memory into an on-chip buffer through a simple write port.
//
// Ports:
//   clk, reset          - clock, synchronous active-high reset
//   start               - one-cycle command strobe (sampled in IDLE only)
//   src_addr, dst_addr  - first off-chip byte address / first buffer address
//   length              - number of words (0..256)
//   busy, done, err     - status: busy during transfer, done pulse, sticky error
//   m_axi_ar*, m_axi_r* - AXI4-Lite read address / read data channels
//   buf_we, buf_addr,
//   buf_din             - buffer write port, one write per returned word
module axi_lite_mem_loader #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int BUF_ADDR_WIDTH = 8,
    parameter int LEN_WIDTH      = 9,
    parameter int ADDR_STEP      = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [ADDR_WIDTH-1:0]     src_addr,
    input  logic [BUF_ADDR_WIDTH-1:0] dst_addr,
    input  logic [LEN_WIDTH-1:0]      length,
    output logic                      busy,
    output logic                      done,
    output logic                      err,
    output logic [ADDR_WIDTH-1:0]     m_axi_araddr,
    output logic [2:0]                m_axi_arprot,
    output logic                      m_axi_arvalid,
    input  logic                      m_axi_arready,
    input  logic [DATA_WIDTH-1:0]     m_axi_rdata,
    input  logic [1:0]                m_axi_rresp,
    input  logic                      m_axi_rvalid,
    output logic                      m_axi_rready,
    output logic                      buf_we,
    output logic [BUF_ADDR_WIDTH-1:0] buf_addr,
    output logic [DATA_WIDTH-1:0]     buf_din
);

    typedef enum logic [1:0] {IDLE, AR, R, FIN} state_t;

    state_t                    state_q, state_d;
    logic [ADDR_WIDTH-1:0]     src_q, src_d;
    logic [BUF_ADDR_WIDTH-1:0] dst_q, dst_d;
    logic [LEN_WIDTH-1:0]      len_q, len_d;
    logic [LEN_WIDTH-1:0]      cnt_q, cnt_d;
    logic [LEN_WIDTH-1:0]      cnt_inc;

    logic                      busy_d, done_d, err_d;
    logic [ADDR_WIDTH-1:0]     araddr_d;
    logic                      arvalid_d, rready_d, buf_we_d;
    logic [BUF_ADDR_WIDTH-1:0] buf_addr_d;
    logic [DATA_WIDTH-1:0]     buf_din_d;

    assign m_axi_arprot = 3'b000;
    assign cnt_inc      = cnt_q + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            src_q         <= '0;
            dst_q         <= '0;
            len_q         <= '0;
            cnt_q         <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            err           <= 1'b0;
            m_axi_araddr  <= '0;
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b0;
            buf_we        <= 1'b0;
            buf_addr      <= '0;
            buf_din       <= '0;
        end else begin
            state_q       <= state_d;
            src_q         <= src_d;
            dst_q         <= dst_d;
            len_q         <= len_d;
            cnt_q         <= cnt_d;
            busy          <= busy_d;
            done          <= done_d;
            err           <= err_d;
            m_axi_araddr  <= araddr_d;
            m_axi_arvalid <= arvalid_d;
            m_axi_rready  <= rready_d;
            buf_we        <= buf_we_d;
            buf_addr      <= buf_addr_d;
            buf_din       <= buf_din_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        src_d      = src_q;
        dst_d      = dst_q;
        len_d      = len_q;
        cnt_d      = cnt_q;
        busy_d     = busy;
        done_d     = 1'b0;
        err_d      = err;
        araddr_d   = m_axi_araddr;
        arvalid_d  = m_axi_arvalid;
        rready_d   = m_axi_rready;
        buf_we_d   = 1'b0;
        buf_addr_d = buf_addr;
        buf_din_d  = buf_din;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    err_d = 1'b0;
                    if (length != '0) begin
                        src_d     = src_addr;
                        dst_d     = dst_addr;
                        len_d     = length;
                        cnt_d     = '0;
                        busy_d    = 1'b1;
                        arvalid_d = 1'b1;
                        araddr_d  = src_addr;
                        state_d   = AR;
                    end else begin
                        // Empty command: report completion, no bus traffic.
                        done_d  = 1'b1;
                        state_d = FIN;
                    end
                end
            end
            AR: begin
                if (m_axi_arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = R;
                end
            end
            R: begin
                if (m_axi_rvalid) begin
                    rready_d   = 1'b0;
                    buf_we_d   = 1'b1;
                    buf_addr_d = dst_q + BUF_ADDR_WIDTH'(cnt_q);
                    buf_din_d  = m_axi_rdata;
                    cnt_d      = cnt_inc;
                    if (m_axi_rresp != 2'b00) err_d = 1'b1;
                    if (cnt_inc == len_q) begin
                        // done lines up with the final buffer write.
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = FIN;
                    end else begin
                        // Next read address overlaps this word's buffer write.
                        arvalid_d = 1'b1;
                        araddr_d  = src_q + ADDR_WIDTH'(cnt_inc)
                                          * ADDR_WIDTH'(ADDR_STEP);
                        state_d   = AR;
                    end
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_axi_lite_mem_loader.sv
// Randomized bench for axi_lite_mem_loader: AXI4-Lite slave model with
// programmable wait states, checked against an arithmetic transfer model.
module tb_axi_lite_mem_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] src_addr;
    logic [7:0]  dst_addr;
    logic [8:0]  length;
    logic        busy, done, err;
    logic [31:0] m_axi_araddr;
    logic [2:0]  m_axi_arprot;
    logic        m_axi_arvalid;
    logic        m_axi_arready;
    logic [31:0] m_axi_rdata;
    logic [1:0]  m_axi_rresp;
    logic        m_axi_rvalid;
    logic        m_axi_rready;
    logic        buf_we;
    logic [7:0]  buf_addr;
    logic [31:0] buf_din;

    axi_lite_mem_loader dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .src_addr      (src_addr),
        .dst_addr      (dst_addr),
        .length        (length),
        .busy          (busy),
        .done          (done),
        .err           (err),
        .m_axi_araddr  (m_axi_araddr),
        .m_axi_arprot  (m_axi_arprot),
        .m_axi_arvalid (m_axi_arvalid),
        .m_axi_arready (m_axi_arready),
        .m_axi_rdata   (m_axi_rdata),
        .m_axi_rresp   (m_axi_rresp),
        .m_axi_rvalid  (m_axi_rvalid),
        .m_axi_rready  (m_axi_rready),
        .buf_we        (buf_we),
        .buf_addr      (buf_addr),
        .buf_din       (buf_din)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int c0      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [79:0] got,
                         input logic [79:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Slave configuration and logs.
    int          ar_delay = 0;
    int          r_delay  = 0;
    int          bad_idx  = -1;
    logic [31:0] d_base   = 0;
    int          ar_idx   = 0;
    int          stall_bad = 0;
    logic [31:0] arq[$];

    // Monitor logs.
    bit          mon_on = 0;
    logic [39:0] wq[$];
    int          wcyc[$];
    int          done_cnt, done_cyc, overlap;
    bit          err_at_done, busy_at_done, busy_seen, busy1, err1;

    // Memory content is a pure function of the word address.
    function automatic logic [31:0] mem_word(input logic [31:0] base,
                                             input logic [31:0] a);
        return base + (a >> 2);
    endfunction

    initial begin : slave
        int          ar_wait, r_wait;
        bit          pending;
        logic [31:0] hold, pend_addr;
        ar_wait = 0; r_wait = 0; pending = 0;
        hold = 0; pend_addr = 0;
        m_axi_arready = 0; m_axi_rvalid = 0;
        m_axi_rdata = 0; m_axi_rresp = 0;
        forever begin
            @(negedge clk);
            m_axi_arready = 0;
            m_axi_rvalid  = 0;
            if (reset) begin
                pending = 0; ar_wait = 0; r_wait = 0;
            end else if (!pending) begin
                if (m_axi_arvalid) begin
                    if (ar_wait == 0) hold = m_axi_araddr;
                    else if (m_axi_araddr != hold) stall_bad++;
                    if (ar_wait >= ar_delay) begin
                        m_axi_arready = 1;
                        pending   = 1;
                        pend_addr = m_axi_araddr;
                        arq.push_back(m_axi_araddr);
                        ar_wait   = 0;
                    end else begin
                        ar_wait++;
                    end
                end else if (ar_wait != 0) begin
                    stall_bad++;
                end
            end else if (m_axi_rready) begin
                if (r_wait >= r_delay) begin
                    m_axi_rvalid = 1;
                    m_axi_rdata  = mem_word(d_base, pend_addr);
                    m_axi_rresp  = (ar_idx == bad_idx) ? 2'b10 : 2'b00;
                    ar_idx++;
                    pending = 0;
                    r_wait  = 0;
                end else begin
                    r_wait++;
                end
            end
        end
    end

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (mon_on) begin
                if (buf_we) begin
                    wq.push_back({buf_addr, buf_din});
                    wcyc.push_back(cyc - c0);
                end
                if (done) begin
                    done_cnt++;
                    done_cyc     = cyc - c0;
                    err_at_done  = err;
                    busy_at_done = busy;
                end
                if (busy) busy_seen = 1;
                if (cyc - c0 == 1) begin
                    busy1 = busy;
                    err1  = err;
                end
                if (m_axi_arvalid && m_axi_rready) overlap++;
            end
        end
    end

    task automatic clear_logs();
        wq.delete(); wcyc.delete(); arq.delete();
        done_cnt = 0; done_cyc = -1; overlap = 0; stall_bad = 0;
        busy_seen = 0; busy1 = 0; err1 = 1; ar_idx = 0;
        err_at_done = 0; busy_at_done = 0;
    endtask

    task automatic run(input logic [31:0] src, input logic [7:0] dst,
                       input int len, input logic [31:0] base,
                       input int ard, input int rd, input int bad,
                       input bit zw, input bit poke);
        logic [31:0] a;
        logic [7:0]  b;
        int          n;
        bit          exp_err;
        ar_delay = ard; r_delay = rd; bad_idx = bad; d_base = base;
        clear_logs();
        @(negedge clk);
        start = 1; src_addr = src; dst_addr = dst; length = len[8:0];
        c0 = cyc; mon_on = 1;
        @(negedge clk);
        start = 0;
        src_addr = $urandom; dst_addr = 8'($urandom);
        length = 9'($urandom);
        if (poke) begin
            repeat (2) @(negedge clk);
            start = 1; src_addr = 32'h1000; dst_addr = 8'h40; length = 9'd1;
            @(negedge clk);
            start = 0;
        end
        n = 0;
        while (done_cnt == 0 && n < 4000) begin
            @(negedge clk);
            n++;
        end
        check("timeout", 80'(done_cnt != 0), 80'd1);
        repeat (4) @(negedge clk);
        mon_on = 0;

        exp_err = (bad >= 0) && (bad < len);
        check("n_wr", 80'(wq.size()), 80'(len));
        check("n_ar", 80'(arq.size()), 80'(len));
        for (int i = 0; i < len && i < wq.size(); i++) begin
            a = src + 32'(4 * i);
            b = dst + 8'(i);
            check("wr", 80'(wq[i]), 80'({b, mem_word(base, a)}));
        end
        for (int i = 0; i < len && i < arq.size(); i++) begin
            a = src + 32'(4 * i);
            check("araddr", 80'(arq[i]), 80'(a));
        end
        check("done_cnt", 80'(done_cnt), 80'd1);
        check("err_done", 80'(err_at_done), 80'(exp_err));
        check("err_clr", 80'(err1), 80'd0);
        check("busy_done", 80'(busy_at_done), 80'd0);
        check("overlap", 80'(overlap), 80'd0);
        check("ar_stable", 80'(stall_bad), 80'd0);
        if (len == 0) begin
            check("busy_len0", 80'(busy_seen), 80'd0);
        end else begin
            check("busy_c1", 80'(busy1), 80'd1);
            if (wcyc.size() > 0)
                check("done_last_we", 80'(done_cyc),
                      80'(wcyc[wcyc.size()-1]));
        end
        if (zw) begin
            check("done_cyc", 80'(done_cyc), 80'(2 * len + 1));
            for (int i = 0; i < len && i < wcyc.size(); i++)
                check("we_cyc", 80'(wcyc[i]), 80'(3 + 2 * i));
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_ctl"},
              80'({busy, done, err, m_axi_arvalid, m_axi_rready, buf_we}),
              80'd0);
        check({tag, "_dat"}, {8'd0, m_axi_araddr, buf_addr, buf_din},
              80'd0);
        check({tag, "_prot"}, 80'(m_axi_arprot), 80'd0);
    endtask

    initial begin : main
        int len, bad, n;
        reset = 1; start = 0;
        src_addr = 0; dst_addr = 0; length = 0;
        repeat (3) @(negedge clk);
        check_zero_outputs("reset");
        reset = 0;

        run(32'h0, 8'h10, 4, 32'hA0, 0, 0, -1, 1, 0);
        run(32'h0, 8'h10, 4, 32'hA0, 3, 2, -1, 0, 0);
        run(32'h20, 8'h33, 0, 32'h5, 0, 0, -1, 1, 0);
        run(32'h100, 8'h00, 3, 32'h77000000, 1, 1, 1, 0, 0);
        run(32'h100, 8'h08, 3, 32'h12340000, 0, 1, -1, 0, 0);
        run(32'hFFFFFFF8, 8'hFE, 4, 32'hC0DE0000, 0, 0, -1, 1, 1);
        run(32'h400, 8'h00, 256, 32'h9000, 0, 0, -1, 1, 0);

        // Reset while the first read is waiting for data.
        ar_delay = 0; r_delay = 50; bad_idx = -1;
        clear_logs();
        @(negedge clk);
        start = 1; src_addr = 32'h80; dst_addr = 8'h20; length = 9'd4;
        c0 = cyc; mon_on = 1;
        @(negedge clk);
        start = 0;
        n = 0;
        while (!m_axi_rready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("rst_wait_r", 80'(m_axi_rready), 80'd1);
        reset = 1;
        @(posedge clk);
        #1;
        check_zero_outputs("midrst");
        @(negedge clk);
        reset = 0;
        repeat (6) @(negedge clk);
        mon_on = 0;
        check("midrst_done", 80'(done_cnt), 80'd0);
        check("midrst_we", 80'(wq.size()), 80'd0);

        run(32'h80, 8'h20, 4, 32'hBEEF0000, 0, 0, -1, 1, 0);

        for (int k = 0; k < 8; k++) begin
            len = $urandom_range(1, 12);
            bad = ($urandom_range(0, 1) == 1) ? $urandom_range(0, len - 1) : -1;
            run($urandom & 32'hFFFFFFFC, 8'($urandom), len, $urandom,
                $urandom_range(0, 3), $urandom_range(0, 3), bad, 0, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/axi_lite_mem_loader.md
Name: axi_lite_mem_loader

Overview:
- AXI4-Lite read master that sits directly upstream of the on-chip buffers and downstream of the off-chip memory slave.
- On a start command it fetches LENGTH consecutive 32-bit words from off-chip memory over the AXI4-Lite read channels.
- Each returned word is written into an on-chip buffer (weight/activation BRAM) through a simple write port.
- One outstanding read at a time.

Parameters:
- DATA_WIDTH, 32, AXI data width and buffer word width.
- ADDR_WIDTH, 32, AXI address width.
- BUF_ADDR_WIDTH, 8, on-chip buffer address width.
- LEN_WIDTH, 9, width of the transfer length (0..256 words).
- ADDR_STEP, 4, araddr increment per word, in bytes.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle command strobe; sampled only in IDLE.
- src_addr  in  ADDR_WIDTH  off-chip byte address of the first word.
- dst_addr  in  BUF_ADDR_WIDTH  buffer address of the first word.
- length  in  LEN_WIDTH  number of words to transfer.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse at transfer end.
- err  out  1  sticky: any non-OKAY rresp during the last transfer; cleared on accepted start.
- m_axi_araddr  out  ADDR_WIDTH  read address.
- m_axi_arprot  out  3  constant 3'b000.
- m_axi_arvalid  out  1  read address valid.
- m_axi_arready  in  1  read address ready.
- m_axi_rdata  in  DATA_WIDTH  read data.
- m_axi_rresp  in  2  read response.
- m_axi_rvalid  in  1  read data valid.
- m_axi_rready  out  1  read data ready.
- buf_we  out  1  buffer write enable, one cycle per word.
- buf_addr  out  BUF_ADDR_WIDTH  buffer write address.
- buf_din  out  DATA_WIDTH  buffer write data.

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values: busy=0, done=0, err=0, m_axi_arvalid=0, m_axi_rready=0, m_axi_araddr=0, buf_we=0, buf_addr=0, buf_din=0. State returns to IDLE.
- States: IDLE, AR, R, FIN. All outputs are registered.
- IDLE:
  - start=1 with length>0: latch src_addr, dst_addr and length; clear the word counter and err; set busy; go to AR.
  - start=1 with length=0: go to FIN. No AXI traffic, busy stays 0, err is cleared.
- AR:
  - m_axi_arvalid=1, m_axi_araddr = src + cnt*ADDR_STEP, modulo 2^ADDR_WIDTH.
  - Hold arvalid and araddr stable until arready=1.
  - On the handshake cycle, drop arvalid next cycle and go to R.
- R:
  - m_axi_rready=1 until rvalid=1.
  - On the handshake cycle:
    - Next cycle: buf_we=1, buf_addr = dst + cnt modulo 2^BUF_ADDR_WIDTH, buf_din = captured rdata.
    - If rresp != 2'b00, set err.
    - Increment cnt, drop rready.
    - If cnt+1 == length go to FIN, else go to AR.
- FIN: done=1 for exactly one cycle, busy=0 in the same cycle, then IDLE.
- Timing with a zero-wait slave (arready=1, rvalid returned the cycle after the AR handshake):
  - One word every 2 cycles.
  - Start at cycle 0: arvalid high at cycle 1, rready high at cycle 2, first buf_we at cycle 3.
  - done coincides with the last buf_we.
- The next AR is issued in the same cycle as the previous word's buf_we.
- start while busy=1 is ignored. In-flight command registers are unaffected.
- An error response does not abort the transfer. All length words are written, including the bad data.
- Address wrap: araddr wraps past 2^ADDR_WIDTH-1; buf_addr wraps past 2^BUF_ADDR_WIDTH-1. No error is flagged for either.
- length=256 with BUF_ADDR_WIDTH=8 fills the whole buffer once.
- Reset mid-transfer:
  - Aborts immediately; all outputs return to reset values next cycle.
  - No done pulse.
  - The slave shares the same reset, so the dropped arvalid/rready is legal.
- Flow control: arvalid and rready are never asserted together. Only one transaction is outstanding.

Test Plan:
- Zero-wait slave, src=0x0, dst=0x10, length=4, memory words 0xA0..0xA3:
  - araddr = 0x0, 0x4, 0x8, 0xC.
  - buf_we at cycles 3, 5, 7, 9, with buf_addr 0x10..0x13 and buf_din 0xA0..0xA3.
  - done at cycle 9, err=0.
- Slave inserts 3-cycle arready and 2-cycle rvalid delays:
  - araddr and arvalid stay stable while waiting.
  - Same 4 buffer writes in order, no extra buf_we, done once.
- length=0:
  - done one cycle after start, no arvalid, no buf_we, busy never high.
- Word 2 of length=3 returns rresp=2'b10:
  - All 3 buf_we occur and err=1 at done.
  - A next start clears err.
- Wrap and busy handling, dst=0xFE, length=4, src=0xFFFFFFF8:
  - buf_addr = 0xFE, 0xFF, 0x00, 0x01.
  - araddr = 0xFFFFFFF8, 0xFFFFFFFC, 0x0, 0x4.
  - A second start mid-transfer is ignored.
- Reset asserted during R state of word 1:
  - Next cycle all outputs are 0 and there is no done pulse.
  - A fresh start after reset completes normally.
